// File: rtl/combinational_logic_if.sv
// -----------------------------------------------------------------------------
// combinational_logic_if
// Bundles the function inputs, the coverage clear and all results of the
// combinational_logic cell.
//   A, B, C   : function inputs, {A,B,C} forms the truth-table index (A = MSB)
//   clr_cov   : synchronous clear of coverage bitmap and rise counter
//   Q         : registered function result
//   q_comb    : unregistered function result
//   seen      : coverage bitmap, one bit per input combination
//   all_seen  : registered "every combination sampled" flag
//   rise_cnt  : saturating count of Q 0->1 transitions
// Modports: master drives inputs and observes results, slave is the cell.
// -----------------------------------------------------------------------------
interface combinational_logic_if #(
  parameter int CNT_W = 8
);
  logic             A;
  logic             B;
  logic             C;
  logic             clr_cov;
  logic             Q;
  logic             q_comb;
  logic [7:0]       seen;
  logic             all_seen;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output A, B, C, clr_cov,
    input  Q, q_comb, seen, all_seen, rise_cnt
  );

  modport slave (
    input  A, B, C, clr_cov,
    output Q, q_comb, seen, all_seen, rise_cnt
  );
endinterface

// File: rtl/combinational_logic.sv
// -----------------------------------------------------------------------------
// combinational_logic
// Registered 3-input Boolean function evaluator with input-combination
// coverage tracking and a saturating counter of Q rising transitions.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, release synchronised internally
//   bus    : combinational_logic_if.slave (A, B, C, clr_cov in;
//            Q, q_comb, seen, all_seen, rise_cnt out)
// Parameters:
//   TRUTH_TABLE : bit i is the function output for index i = {A,B,C}
//   CNT_W       : width of rise_cnt, must match the interface CNT_W
// -----------------------------------------------------------------------------
module combinational_logic #(
  parameter logic [7:0] TRUTH_TABLE = 8'hE8,
  parameter int         CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  combinational_logic_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       idx;
  logic             q_next;
  logic             run_en;
  logic             q_r;
  logic [7:0]       seen_r;
  logic [7:0]       seen_next;
  logic             all_seen_r;
  logic [CNT_W-1:0] rise_cnt_r;

  assign idx    = {bus.A, bus.B, bus.C};
  assign q_next = TRUTH_TABLE[idx];

  // Reset is asserted asynchronously but released through this flop, so the
  // first edge that sees rst_n high only arms the cell and the edge after it
  // performs the first real update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en <= 1'b0;
    end else begin
      run_en <= 1'b1;
    end
  end

  // Clear wins over recording the current index.
  always_comb begin
    seen_next = seen_r;
    if (bus.clr_cov) begin
      seen_next = 8'h00;
    end else begin
      seen_next[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= 1'b0;
      seen_r     <= 8'h00;
      all_seen_r <= 1'b0;
      rise_cnt_r <= '0;
    end else if (run_en) begin
      q_r        <= q_next;
      seen_r     <= seen_next;
      all_seen_r <= &seen_next;
      // A rise is old Q low and the value about to be registered high.
      if (bus.clr_cov) begin
        rise_cnt_r <= '0;
      end else if (!q_r && q_next && (rise_cnt_r != CNT_MAX)) begin
        rise_cnt_r <= rise_cnt_r + 1'b1;
      end
    end
  end

  assign bus.Q        = q_r;
  assign bus.q_comb   = q_next;
  assign bus.seen     = seen_r;
  assign bus.all_seen = all_seen_r;
  assign bus.rise_cnt = rise_cnt_r;

endmodule

// File: tb/tb_combinational_logic.sv
// -----------------------------------------------------------------------------
// tb_combinational_logic
// Directed bench for combinational_logic. Three instances share clk, rst_n and
// the input vectors: default majority table (CNT_W=8), majority with a 2-bit
// counter for saturation, and an XOR table override.
// -----------------------------------------------------------------------------
module tb_combinational_logic;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;

  combinational_logic_if #(.CNT_W(8)) bus_maj ();
  combinational_logic_if #(.CNT_W(2)) bus_sat ();
  combinational_logic_if #(.CNT_W(8)) bus_xor ();

  combinational_logic #(.TRUTH_TABLE(8'hE8), .CNT_W(8)) u_maj (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_maj)
  );

  combinational_logic #(.TRUTH_TABLE(8'hE8), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  combinational_logic #(.TRUTH_TABLE(8'h96), .CNT_W(8)) u_xor (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_xor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the stimulus process.
  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic clr);
    bus_maj.A = a; bus_maj.B = b; bus_maj.C = c; bus_maj.clr_cov = clr;
    bus_sat.A = a; bus_sat.B = b; bus_sat.C = c; bus_sat.clr_cov = clr;
    bus_xor.A = a; bus_xor.B = b; bus_xor.C = c; bus_xor.clr_cov = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed tables, index 0..7
  logic [7:0] exp_maj  = 8'b1110_1000;
  logic [7:0] exp_xor  = 8'b1001_0110;
  logic [7:0] exp_seen [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

  initial begin
    logic [2:0] v;
    n_checks = 0;
    n_pass   = 0;

    // Reset with all inputs high
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rst_Q", {31'd0, bus_maj.Q}, 32'd0);
    checkOutput("rst_seen", {24'd0, bus_maj.seen}, 32'h00);
    checkOutput("rst_all_seen", {31'd0, bus_maj.all_seen}, 32'd0);
    checkOutput("rst_rise_cnt", {24'd0, bus_maj.rise_cnt}, 32'd0);
    checkOutput("rst_q_comb", {31'd0, bus_maj.q_comb}, 32'd1);

    // Release; the first edge only arms the reset synchroniser
    rst_n = 1'b1;
    tick();
    checkOutput("sync_seen", {24'd0, bus_maj.seen}, 32'h00);
    checkOutput("sync_Q", {31'd0, bus_maj.Q}, 32'd0);

    // Exhaustive sweep 000..111
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(v[2], v[1], v[0], 1'b0);
      #1;
      checkOutput($sformatf("xor_q_comb_%0d", i), {31'd0, bus_xor.q_comb}, {31'd0, exp_xor[i]});
      checkOutput($sformatf("maj_q_comb_%0d", i), {31'd0, bus_maj.q_comb}, {31'd0, exp_maj[i]});
      tick();
      checkOutput($sformatf("maj_Q_%0d", i), {31'd0, bus_maj.Q}, {31'd0, exp_maj[i]});
      checkOutput($sformatf("xor_Q_%0d", i), {31'd0, bus_xor.Q}, {31'd0, exp_xor[i]});
      checkOutput($sformatf("seen_%0d", i), {24'd0, bus_maj.seen}, {24'd0, exp_seen[i]});
      checkOutput($sformatf("all_seen_%0d", i), {31'd0, bus_maj.all_seen}, (i == 7) ? 32'd1 : 32'd0);
    end
    checkOutput("sweep_rise_maj", {24'd0, bus_maj.rise_cnt}, 32'd2);
    checkOutput("sweep_rise_sat", {30'd0, bus_sat.rise_cnt}, 32'd2);
    checkOutput("sweep_rise_xor", {24'd0, bus_xor.rise_cnt}, 32'd3);

    // Clear with 101 on the same edge
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("clr_seen", {24'd0, bus_maj.seen}, 32'h00);
    checkOutput("clr_rise_cnt", {24'd0, bus_maj.rise_cnt}, 32'd0);
    checkOutput("clr_all_seen", {31'd0, bus_maj.all_seen}, 32'd0);
    checkOutput("clr_Q", {31'd0, bus_maj.Q}, 32'd1);
    checkOutput("clr_xor_Q", {31'd0, bus_xor.Q}, 32'd0);

    // Rising edge counting: 000, 011, 000, 110, 111 -> Q 0,1,0,1,1
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("rise_Q_000", {31'd0, bus_maj.Q}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("rise_Q_011", {31'd0, bus_maj.Q}, 32'd1);
    checkOutput("rise_cnt_011", {24'd0, bus_maj.rise_cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("rise_Q_000b", {31'd0, bus_maj.Q}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("rise_Q_110", {31'd0, bus_maj.Q}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("rise_Q_111", {31'd0, bus_maj.Q}, 32'd1);
    checkOutput("rise_cnt_end", {24'd0, bus_maj.rise_cnt}, 32'd2);
    checkOutput("rise_seen", {24'd0, bus_maj.seen}, 32'hC9);
    checkOutput("rise_all_seen", {31'd0, bus_maj.all_seen}, 32'd0);

    // Saturation: clear with 000, then five 0->1 transitions of Q
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("sat_clr", {30'd0, bus_sat.rise_cnt}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0); tick();
      checkOutput($sformatf("sat_cnt_%0d", k), {30'd0, bus_sat.rise_cnt}, (k > 3) ? 32'd3 : 32'(k));
      checkOutput($sformatf("wide_cnt_%0d", k), {24'd0, bus_maj.rise_cnt}, 32'(k));
      if (k < 5) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); tick();
      end
    end

    // Constant inputs: nothing moves
    tick();
    tick();
    checkOutput("hold_Q", {31'd0, bus_maj.Q}, 32'd1);
    checkOutput("hold_cnt", {24'd0, bus_maj.rise_cnt}, 32'd5);
    checkOutput("hold_sat_cnt", {30'd0, bus_sat.rise_cnt}, 32'd3);
    checkOutput("hold_seen", {24'd0, bus_maj.seen}, 32'h81);

    // Asynchronous reset mid-operation, checked before any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_Q", {31'd0, bus_maj.Q}, 32'd0);
    checkOutput("arst_seen", {24'd0, bus_maj.seen}, 32'h00);
    checkOutput("arst_cnt", {24'd0, bus_maj.rise_cnt}, 32'd0);
    checkOutput("arst_q_comb", {31'd0, bus_maj.q_comb}, 32'd1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rearm_seen", {24'd0, bus_maj.seen}, 32'h00);
    tick();
    checkOutput("restart_seen", {24'd0, bus_maj.seen}, 32'h04);
    checkOutput("restart_Q", {31'd0, bus_maj.Q}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
